rom_writer: RTL and testbench

Downstream consumer of the system controller's ROM-loading byte stream (`rom_loading`, `rom_do`, `rom_do_valid`). It packs bytes into little-endian 16-bit words and buffers them in a small FIFO. It writes them sequentially to the core's memory controller (SDRAM) over a req/ack handshake, then flushes any odd trailing byte and reports the loaded size with a completion pulse.

---
 rtl/rom_writer.sv | 173 +++++++++++++++++
 tb/tb_rom_writer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_writer.sv
// rom_writer: packs the system controller's ROM byte stream into little-endian
// 16-bit words, buffers them in a small FIFO, and writes them to memory over a
// req/ack handshake. Reports the loaded byte count and pulses done at the end.
module rom_writer #(
  parameter int ADDR_W     = 22,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rom_loading,
  input  logic [7:0]        rom_do,
  input  logic              rom_do_valid,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [1:0]        mem_be,
  output logic [23:0]       rom_size,
  output logic              loader_busy,
  output logic              loader_done,
  output logic              overflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  // One extra bit so a full 2^24-byte image is representable internally.
  localparam logic [24:0]       SIZE_MAX = 25'd1 << (ADDR_W + 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [CNT_W-1:0]  DEPTH    = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [24:0]       size_q, size_d;
  logic              ovf_q, ovf_d;
  logic              pend_q, pend_d;
  logic [7:0]        low_q, low_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [PTR_W-1:0]  wptr_q, rptr_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;

  logic              push, pop, full, word_done;
  logic [15:0]       push_data;
  logic [1:0]        push_be;

  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [15:0]       fifo_data_q [FIFO_DEPTH];
  logic [1:0]        fifo_be_q   [FIFO_DEPTH];

  // A pop frees a slot in the same cycle, so push+pop on a full FIFO is legal.
  assign pop  = (cnt_q != '0) && mem_ack;
  assign full = (cnt_q == DEPTH) && !pop;

  // Next-state, byte packing and FIFO push decision.
  always_comb begin
    state_d   = state_q;
    size_d    = size_q;
    ovf_d     = ovf_q;
    pend_d    = pend_q;
    low_d     = low_q;
    waddr_d   = waddr_q;
    done_d    = 1'b0;
    push      = 1'b0;
    word_done = 1'b0;
    push_data = 16'h0000;
    push_be   = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (rom_loading) begin
          size_d  = '0;
          ovf_d   = 1'b0;
          pend_d  = 1'b0;
          waddr_d = BASE;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (rom_do_valid) begin
          if (size_q == SIZE_MAX) begin
            ovf_d = 1'b1;
          end else begin
            size_d = size_q + 25'd1;
            if (!pend_q) begin
              low_d  = rom_do;
              pend_d = 1'b1;
            end else begin
              pend_d    = 1'b0;
              push_data = {rom_do, low_q};
              push_be   = 2'b11;
              word_done = 1'b1;
            end
          end
        end
        if (!rom_loading) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (pend_q) begin
          pend_d    = 1'b0;
          push_data = {8'h00, low_q};
          push_be   = 2'b01;
          word_done = 1'b1;
        end
        state_d = S_DRAIN;
      end
      default: begin
        // Finished once the FIFO is empty or its last entry pops this cycle.
        if (cnt_q == {{(CNT_W-1){1'b0}}, pop}) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
    endcase
    // Dropped words still consume an address so later data keeps its offset.
    if (word_done) begin
      waddr_d = waddr_q + ADDR_W'(1);
      if (full) ovf_d = 1'b1;
      else      push  = 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state and FIFO pointers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      size_q  <= '0;
      ovf_q   <= 1'b0;
      pend_q  <= 1'b0;
      waddr_q <= BASE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      ovf_q   <= ovf_d;
      pend_q  <= pend_d;
      waddr_q <= waddr_d;
      wptr_q  <= wptr_q + PTR_W'(push);
      rptr_q  <= rptr_q + PTR_W'(pop);
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Data storage: pending low byte and FIFO entries, qualified by control.
  always_ff @(posedge clk) begin
    low_q <= low_d;
    if (push) begin
      fifo_addr_q[wptr_q] <= waddr_q;
      fifo_data_q[wptr_q] <= push_data;
      fifo_be_q[wptr_q]   <= push_be;
    end
  end

  // Head entry is driven straight from storage; idle values when empty.
  assign mem_req     = (cnt_q != '0);
  assign mem_addr    = mem_req ? fifo_addr_q[rptr_q] : BASE;
  assign mem_wdata   = mem_req ? fifo_data_q[rptr_q] : 16'h0000;
  assign mem_be      = mem_req ? fifo_be_q[rptr_q]   : 2'b00;
  assign rom_size    = size_q[23:0];
  assign loader_busy = (state_q != S_IDLE);
  assign loader_done = done_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_rom_writer.sv
// tb_rom_writer: directed bench for rom_writer with a write scoreboard.
module tb_rom_writer;
  localparam int AW    = 22;
  localparam int BASE  = 'h3FFFFE;
  localparam int DEPTH = 4;
  typedef logic [AW+17:0] ent_t;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          rom_loading = 1'b0;
  logic [7:0]    rom_do = 8'h00;
  logic          rom_do_valid = 1'b0;
  logic          mem_ack = 1'b0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic [1:0]    mem_be;
  logic [23:0]   rom_size;
  logic          loader_busy, loader_done, overflow;

  rom_writer #(.ADDR_W(AW), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .rom_loading(rom_loading), .rom_do(rom_do),
    .rom_do_valid(rom_do_valid), .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .rom_size(rom_size), .loader_busy(loader_busy), .loader_done(loader_done),
    .overflow(overflow));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int ack_mode = 0;
  int cyc = 0;
  int d0;
  ent_t sb[$];
  logic tb_pend = 1'b0;
  logic [7:0] tb_low = 8'h00;
  int tb_widx = 0;
  int keep_words = 1 << 30;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset();
    check("rst_req", mem_req, 0);
    check("rst_addr", mem_addr, BASE);
    check("rst_wdata", mem_wdata, 0);
    check("rst_be", mem_be, 0);
    check("rst_size", rom_size, 0);
    check("rst_busy", loader_busy, 0);
    check("rst_done", loader_done, 0);
    check("rst_ovf", overflow, 0);
  endtask

  // Reference packer: expected writes are queued as bytes are driven.
  task automatic model_reset();
    tb_pend = 1'b0;
    tb_widx = 0;
  endtask

  task automatic model_push(input logic [15:0] d, input logic [1:0] be);
    logic [AW-1:0] a;
    a = AW'(BASE + tb_widx);
    if (tb_widx < keep_words) sb.push_back({a, d, be});
    tb_widx++;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (!tb_pend) begin
      tb_low  = b;
      tb_pend = 1'b1;
    end else begin
      model_push({b, tb_low}, 2'b11);
      tb_pend = 1'b0;
    end
  endtask

  task automatic model_flush();
    if (tb_pend) model_push({8'h00, tb_low}, 2'b01);
    tb_pend = 1'b0;
  endtask

  task automatic start_load();
    @(posedge clk); #1;
    rom_loading = 1'b1;
    model_reset();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge clk); #1;
    rom_do = b;
    rom_do_valid = 1'b1;
    model_byte(b);
    @(posedge clk); #1;
    rom_do_valid = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic end_load();
    @(posedge clk); #1;
    rom_loading = 1'b0;
    model_flush();
  endtask

  task automatic end_load_with(input logic [7:0] b);
    @(posedge clk); #1;
    rom_do = b;
    rom_do_valid = 1'b1;
    rom_loading = 1'b0;
    model_byte(b);
    model_flush();
    @(posedge clk); #1;
    rom_do_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < limit) begin
      @(negedge clk);
      n++;
      if (loader_done) seen = 1'b1;
    end
    checks++;
    assert (seen) else begin
      errors++;
      $error("FAIL done_timeout: observed=no pulse expected=pulse within %0d cycles", limit);
    end
    if (seen) begin
      check("done_not_busy", loader_busy, 0);
      check("done_sb_empty", sb.size(), 0);
    end
  endtask

  // Ack generator; the random mode still acks at least once every 4 cycles.
  initial begin
    forever begin
      @(posedge clk); #1;
      cyc++;
      case (ack_mode)
        0:       mem_ack = 1'b0;
        1:       mem_ack = 1'b1;
        default: mem_ack = ($urandom_range(0, 3) != 0) || ((cyc % 4) == 0);
      endcase
    end
  end

  // Write monitor: scoreboard compare on accepted writes, hold check on stalls.
  initial begin
    logic prev_req, prev_ack, prev_rst;
    ent_t prev_ent, cur, exp;
    prev_req = 1'b0;
    prev_ack = 1'b0;
    prev_rst = 1'b0;
    prev_ent = '0;
    forever begin
      @(negedge clk);
      cur = {mem_addr, mem_wdata, mem_be};
      if (resetn && prev_rst) begin
        if (prev_req && !prev_ack) begin
          check("hold_req", mem_req, 1);
          check("hold_entry", cur, prev_ent);
        end
        if (mem_req && mem_ack) begin
          checks++;
          assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_write: observed=%0h expected=no write", cur);
          end
          if (sb.size() != 0) begin
            exp = sb.pop_front();
            check("write", cur, exp);
          end
        end
        if (loader_done) done_cnt++;
      end
      prev_req = mem_req;
      prev_ack = mem_ack;
      prev_ent = cur;
      prev_rst = resetn;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset();
    #1 resetn = 1'b1;

    // Four bytes, ack always high
    ack_mode = 1;
    start_load();
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    end_load();
    d0 = done_cnt;
    wait_done(50);
    @(negedge clk);
    check("t1_size", rom_size, 4);
    check("t1_ovf", overflow, 0);
    check("t1_done_once", done_cnt, d0 + 1);

    // Odd byte count, last byte arrives with the falling load level
    start_load();
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    end_load_with(8'hCC);
    wait_done(50);
    check("t2_size", rom_size, 3);

    // Zero-byte load: done exactly 3 cycles after the fall
    start_load();
    end_load();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t3_done_early", loader_done, 0);
    @(posedge clk);
    @(negedge clk);
    check("t3_done", loader_done, 1);
    check("t3_size", rom_size, 0);

    // Ack held low: 4 words buffered, words 4 and 5 dropped
    ack_mode = 0;
    keep_words = 4;
    start_load();
    for (int i = 0; i < 12; i++) send_byte(8'h10 + 8'(i), 14);
    @(negedge clk);
    check("t4_ovf", overflow, 1);
    check("t4_size", rom_size, 12);
    check("t4_req", mem_req, 1);
    ack_mode = 1;
    end_load();
    wait_done(100);
    check("t4_ovf_sticky", overflow, 1);
    keep_words = 1 << 30;

    // Long load with random stalls
    ack_mode = 2;
    start_load();
    for (int i = 0; i < 1000; i++) send_byte(8'($urandom_range(0, 255)), 0);
    end_load();
    wait_done(200);
    check("t5_size", rom_size, 1000);
    check("t5_ovf", overflow, 0);

    // Reset pulse mid-load with a request outstanding
    ack_mode = 0;
    start_load();
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    @(negedge clk);
    check("t6_req_before", mem_req, 1);
    @(posedge clk); #1;
    resetn = 1'b0;
    rom_loading = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset();
    #1 resetn = 1'b1;
    sb.delete();
    ack_mode = 1;
    start_load();
    send_byte(8'h5A, 0);
    send_byte(8'hA5, 0);
    send_byte(8'hC3, 0);
    end_load();
    wait_done(50);
    check("t6_size", rom_size, 3);

    // New load requested while draining
    ack_mode = 0;
    keep_words = 4;
    start_load();
    for (int i = 0; i < 10; i++) send_byte(8'h80 + 8'(i), 1);
    @(negedge clk);
    check("t7_ovf", overflow, 1);
    end_load();
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("t7_drain_busy", loader_busy, 1);
    @(posedge clk); #1;
    rom_loading = 1'b1;
    ack_mode = 1;
    d0 = done_cnt;
    wait_done(50);
    @(negedge clk);
    check("t7_done_once", done_cnt, d0 + 1);
    check("t7_new_busy", loader_busy, 1);
    check("t7_new_ovf", overflow, 0);
    check("t7_new_size", rom_size, 0);
    keep_words = 1 << 30;
    model_reset();
    send_byte(8'h77, 0);
    send_byte(8'h88, 0);
    end_load();
    wait_done(50);
    check("t7_size", rom_size, 2);
    check("t7_ovf_end", overflow, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
